// File: rtl/ethernet_rx_controller_pkg.sv
// Constants shared by the Gigex receive and transmit controllers.
package ethernet_rx_controller_pkg;

   localparam int GIGEX_BYTES_PER_WORD = 16;
   localparam int GIGEX_WORD_W         = 128;
   localparam int GIGEX_CHAN_W         = 3;
   localparam int GIGEX_FLOW_LATENCY   = 2;
   localparam int GIGEX_IDX_W          = $clog2(GIGEX_BYTES_PER_WORD);

   typedef logic [GIGEX_WORD_W-1:0] gigex_word_t;

endpackage

// File: rtl/gigex_word_fifo.sv
// Falling-edge first-word-fall-through FIFO for assembled Gigex words.
// A push into a full FIFO is accepted only when a pop happens on the same edge.
module gigex_word_fifo
   import ethernet_rx_controller_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int AW    = $clog2(DEPTH),
   parameter int CW    = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push_i,
   input  gigex_word_t       push_data_i,
   input  logic              pop_i,
   output gigex_word_t       data_o,
   output logic              empty_o,
   output logic              full_o,
   output logic [CW-1:0]     count_o
);

   gigex_word_t       mem_q [DEPTH];
   logic [AW-1:0]     wrPtr_q;
   logic [AW-1:0]     wrPtr_d;
   logic [AW-1:0]     rdPtr_q;
   logic [AW-1:0]     rdPtr_d;
   logic [CW-1:0]     count_q;
   logic [CW-1:0]     count_d;
   logic              doPush;
   logic              doPop;

   // Qualify push/pop against occupancy and compute the next pointers and count.
   always_comb begin
      doPop   = pop_i & (count_q != '0);
      doPush  = push_i & ((count_q != CW'(DEPTH)) | doPop);
      wrPtr_d = wrPtr_q;
      rdPtr_d = rdPtr_q;
      count_d = count_q + CW'(doPush) - CW'(doPop);
      if (doPush) begin
         wrPtr_d = wrPtr_q + 1'b1;
      end
      if (doPop) begin
         rdPtr_d = rdPtr_q + 1'b1;
      end
   end

   // Pointer and occupancy registers, cleared by reset so stored words are forgotten.
   always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
      end else begin
         wrPtr_q <= wrPtr_d;
         rdPtr_q <= rdPtr_d;
         count_q <= count_d;
      end
   end

   // Word storage; contents only become visible through the occupancy count.
   always_ff @(negedge clk) begin
      if (doPush) begin
         mem_q[wrPtr_q] <= push_data_i;
      end
   end

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == CW'(DEPTH));
   assign count_o = count_q;
   assign data_o  = empty_o ? '0 : mem_q[rdPtr_q];

endmodule

// File: rtl/ethernet_rx_controller.sv
// Gigex receive path: filters one channel, packs 16 bytes into a 128-bit word
// (first byte most significant), queues words for the backend and raises a
// busy flag early enough to absorb the Gigex flow-control latency.
module ethernet_rx_controller
   import ethernet_rx_controller_pkg::*;
#(
   parameter int CHANNEL    = 0,
   parameter int FIFO_DEPTH = 4,
   parameter int CNT_W      = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [7:0]              byte_in,
   input  logic                    byte_in_valid,
   input  logic [GIGEX_CHAN_W-1:0] channel_in,
   output logic                    rx_busy,
   output logic [GIGEX_WORD_W-1:0] data,
   output logic                    valid,
   input  logic                    ready,
   output logic                    overflow,
   output logic [CNT_W-1:0]        dropped_count,
   input  logic                    clear_status
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam int HEADROOM_WORDS =
      (GIGEX_FLOW_LATENCY + GIGEX_BYTES_PER_WORD - 1) / GIGEX_BYTES_PER_WORD;
   localparam logic [CW-1:0] BUSY_LEVEL = CW'(FIFO_DEPTH - HEADROOM_WORDS);
   localparam logic [GIGEX_IDX_W-1:0] LAST_IDX = GIGEX_IDX_W'(GIGEX_BYTES_PER_WORD - 1);

   logic [GIGEX_IDX_W-1:0] idx_q;
   logic [GIGEX_IDX_W-1:0] idx_d;
   gigex_word_t            asm_q;
   gigex_word_t            asm_d;
   logic                   asmFull_q;
   logic                   asmFull_d;
   logic                   overflow_q;
   logic                   overflow_d;
   logic [CNT_W-1:0]       dropCnt_q;
   logic [CNT_W-1:0]       dropCnt_d;
   logic                   rxBusy_q;
   logic                   rxBusy_d;

   logic                   chanMatch;
   logic                   fifoPush;
   logic                   fifoPop;
   logic                   fifoRoom;
   logic                   fifoEmpty;
   logic                   fifoFull;
   logic [CW-1:0]          fifoCount;
   logic [CW-1:0]          fifoCountNext;
   gigex_word_t            fifoData;
   gigex_word_t            pushWord;
   gigex_word_t            completedWord;
   logic                   dropByte;
   logic                   lostByte;

   // Assembler: shift accepted bytes in, hand complete words to the FIFO or hold
   // them when it is full; anything arriving while a word is held is lost.
   always_comb begin
      chanMatch     = (channel_in == GIGEX_CHAN_W'(CHANNEL));
      fifoPop       = ~fifoEmpty & ready;
      fifoRoom      = ~fifoFull | fifoPop;
      completedWord = {asm_q[GIGEX_WORD_W-9:0], byte_in};
      idx_d         = idx_q;
      asm_d         = asm_q;
      asmFull_d     = asmFull_q;
      fifoPush      = 1'b0;
      pushWord      = asm_q;
      dropByte      = 1'b0;
      lostByte      = 1'b0;
      if (asmFull_q) begin
         if (fifoRoom) begin
            fifoPush  = 1'b1;
            asmFull_d = 1'b0;
         end
         if (byte_in_valid) begin
            dropByte = 1'b1;
            lostByte = chanMatch;
         end
      end else if (byte_in_valid) begin
         if (!chanMatch) begin
            dropByte = 1'b1;
         end else begin
            asm_d = completedWord;
            if (idx_q == LAST_IDX) begin
               idx_d = '0;
               if (fifoRoom) begin
                  fifoPush = 1'b1;
                  pushWord = completedWord;
               end else begin
                  asmFull_d = 1'b1;
               end
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
      end
   end

   // Status and flow control: sticky overflow, saturating drop counter (clear
   // has priority) and busy raised while only the headroom slot is left.
   always_comb begin
      overflow_d    = overflow_q | lostByte;
      dropCnt_d     = dropCnt_q;
      if (dropByte && (dropCnt_q != '1)) begin
         dropCnt_d = dropCnt_q + 1'b1;
      end
      if (clear_status) begin
         overflow_d = 1'b0;
         dropCnt_d  = '0;
      end
      fifoCountNext = fifoCount + CW'(fifoPush) - CW'(fifoPop);
      rxBusy_d      = (fifoCountNext >= BUSY_LEVEL) | asmFull_d;
   end

   // State registers on the Gigex falling edge; reset discards any partial word.
   always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q      <= '0;
         asm_q      <= '0;
         asmFull_q  <= 1'b0;
         overflow_q <= 1'b0;
         dropCnt_q  <= '0;
         rxBusy_q   <= 1'b0;
      end else begin
         idx_q      <= idx_d;
         asm_q      <= asm_d;
         asmFull_q  <= asmFull_d;
         overflow_q <= overflow_d;
         dropCnt_q  <= dropCnt_d;
         rxBusy_q   <= rxBusy_d;
      end
   end

   gigex_word_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk         (clk),
      .rst_n       (rst_n),
      .push_i      (fifoPush),
      .push_data_i (pushWord),
      .pop_i       (fifoPop),
      .data_o      (fifoData),
      .empty_o     (fifoEmpty),
      .full_o      (fifoFull),
      .count_o     (fifoCount)
   );

   assign data          = fifoData;
   assign valid         = ~fifoEmpty;
   assign rx_busy       = rxBusy_q;
   assign overflow      = overflow_q;
   assign dropped_count = dropCnt_q;

endmodule

// File: tb/tb_ethernet_rx_controller.sv
// Self-checking bench for the Gigex receive controller with a queue-based model.
module tb_ethernet_rx_controller;
   import ethernet_rx_controller_pkg::*;

   localparam int CHANNEL    = 0;
   localparam int FIFO_DEPTH = 4;
   localparam int CNT_W      = 16;
   localparam int DROP_MAX   = (1 << CNT_W) - 1;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [7:0]   byte_in = '0;
   logic         byte_in_valid = 1'b0;
   logic [2:0]   channel_in = '0;
   logic         rx_busy;
   logic [127:0] data;
   logic         valid;
   logic         ready = 1'b0;
   logic         overflow;
   logic [CNT_W-1:0] dropped_count;
   logic         clear_status = 1'b0;

   int errors = 0;
   int checks = 0;

   logic [127:0] mq[$];
   logic [127:0] gotQ[$];
   logic [127:0] expQ[$];
   logic [7:0]   partial[$];
   bit           mHeld;
   logic [127:0] mHeldWord;
   int           mDropped;
   bit           mOverflow;
   logic         sampledBusy;

   ethernet_rx_controller #(
      .CHANNEL    (CHANNEL),
      .FIFO_DEPTH (FIFO_DEPTH),
      .CNT_W      (CNT_W)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .byte_in       (byte_in),
      .byte_in_valid (byte_in_valid),
      .channel_in    (channel_in),
      .rx_busy       (rx_busy),
      .data          (data),
      .valid         (valid),
      .ready         (ready),
      .overflow      (overflow),
      .dropped_count (dropped_count),
      .clear_status  (clear_status)
   );

   // Free-running clock; the design acts on the falling edge, the bench on the rising one.
   always #5 clk = ~clk;

   // Watchdog so a stuck run still terminates.
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   function automatic logic [127:0] packFrom(input logic [7:0] src[$], input int start);
      logic [127:0] w;
      w = '0;
      for (int i = 0; i < 16; i++) w[127-8*i -: 8] = src[start+i];
      return w;
   endfunction

   task automatic modelReset();
      mq.delete();
      partial.delete();
      mHeld     = 1'b0;
      mHeldWord = '0;
      mDropped  = 0;
      mOverflow = 1'b0;
   endtask

   // One clock: drive inputs on the rising edge, record the handshake and
   // advance the behavioural model for the following falling edge.
   task automatic step(input logic bv, input logic [7:0] b, input logic [2:0] ch,
                       input logic rdy, input logic clr);
      bit wasHeld;
      logic [127:0] w;
      @(posedge clk);
      byte_in       = b;
      byte_in_valid = bv;
      channel_in    = ch;
      ready         = rdy;
      clear_status  = clr;
      #1;
      sampledBusy = rx_busy;
      if (valid === 1'b1 && rdy) gotQ.push_back(data);
      if (mq.size() > 0 && rdy) expQ.push_back(mq.pop_front());
      wasHeld = mHeld;
      if (mHeld && mq.size() < FIFO_DEPTH) begin
         mq.push_back(mHeldWord);
         mHeld = 1'b0;
      end
      if (bv) begin
         if (wasHeld || ch != 3'(CHANNEL)) begin
            if (mDropped < DROP_MAX) mDropped++;
            if (wasHeld && ch == 3'(CHANNEL)) mOverflow = 1'b1;
         end else begin
            partial.push_back(b);
            if (partial.size() == 16) begin
               w = '0;
               for (int i = 0; i < 16; i++) w[127-8*i -: 8] = partial[i];
               partial.delete();
               if (mq.size() < FIFO_DEPTH) mq.push_back(w);
               else begin
                  mHeld     = 1'b1;
                  mHeldWord = w;
               end
            end
         end
      end
      if (clr) begin
         mDropped  = 0;
         mOverflow = 1'b0;
      end
   endtask

   task automatic drain(output int n);
      n = 0;
      while ((mq.size() > 0 || mHeld) && n < 100) begin
         step(1'b0, 8'h00, 3'd0, 1'b1, 1'b0);
         n++;
      end
      step(1'b0, 8'h00, 3'd0, 1'b1, 1'b0);
      step(1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
   endtask

   task automatic doReset();
      @(posedge clk);
      rst_n         = 1'b0;
      byte_in_valid = 1'b0;
      ready         = 1'b0;
      clear_status  = 1'b0;
      modelReset();
      #1;
   endtask

   task automatic releaseReset();
      @(posedge clk);
      @(posedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      @(posedge clk);
      @(posedge clk);
      #1;
      checks++; if (rx_busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b want 0", rx_busy); end
      checks++; if (valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b want 0", valid); end
      checks++; if (data !== 128'h0) begin errors++; $display("[TB] FAIL reset_data: got %h want 0", data); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_overflow: got %b want 0", overflow); end
      checks++; if (dropped_count !== '0) begin errors++; $display("[TB] FAIL reset_dropped: got %0d want 0", dropped_count); end
      modelReset();
      releaseReset();
   endtask

   task automatic test_single_word();
      bit busySeen;
      logic [127:0] want;
      want = 128'h000102030405060708090A0B0C0D0E0F;
      gotQ.delete(); expQ.delete();
      busySeen = 1'b0;
      for (int i = 0; i < 16; i++) begin
         step(1'b1, 8'(i), 3'd0, 1'b1, 1'b0);
         if (sampledBusy !== 1'b0) busySeen = 1'b1;
      end
      step(1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
      checks++; if (valid !== 1'b1) begin errors++; $display("[TB] FAIL single_valid_latency: got %b want 1", valid); end
      checks++; if (data !== want) begin errors++; $display("[TB] FAIL single_data: got %h want %h", data, want); end
      step(1'b0, 8'h00, 3'd0, 1'b1, 1'b0);
      if (sampledBusy !== 1'b0) busySeen = 1'b1;
      step(1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
      checks++; if (valid !== 1'b0) begin errors++; $display("[TB] FAIL single_valid_after_pop: got %b want 0", valid); end
      checks++; if (gotQ.size() != 1) begin errors++; $display("[TB] FAIL single_count: got %0d want 1", gotQ.size()); end
      else begin
         checks++; if (gotQ[0] !== want) begin errors++; $display("[TB] FAIL single_popped: got %h want %h", gotQ[0], want); end
      end
      checks++; if (busySeen !== 1'b0) begin errors++; $display("[TB] FAIL single_busy: got 1 want 0"); end
   endtask

   task automatic test_channel_filter();
      logic [7:0] good[$];
      bit wrongSlot[19];
      int placed, k, g, n;
      logic [127:0] want;
      gotQ.delete(); expQ.delete();
      step(1'b0, 8'h00, 3'd0, 1'b1, 1'b1);
      for (int i = 0; i < 16; i++) good.push_back(8'($urandom_range(0, 255)));
      for (int i = 0; i < 19; i++) wrongSlot[i] = 1'b0;
      placed = 0;
      while (placed < 3) begin
         k = $urandom_range(0, 18);
         if (!wrongSlot[k]) begin
            wrongSlot[k] = 1'b1;
            placed++;
         end
      end
      g = 0;
      for (int i = 0; i < 19; i++) begin
         if (wrongSlot[i]) step(1'b1, 8'($urandom_range(0, 255)), 3'd5, 1'b1, 1'b0);
         else begin
            step(1'b1, good[g], 3'd0, 1'b1, 1'b0);
            g++;
         end
      end
      drain(n);
      want = packFrom(good, 0);
      checks++; if (gotQ.size() != 1) begin errors++; $display("[TB] FAIL filter_count: got %0d want 1", gotQ.size()); end
      else begin
         checks++; if (gotQ[0] !== want) begin errors++; $display("[TB] FAIL filter_word: got %h want %h", gotQ[0], want); end
      end
      checks++; if (dropped_count !== 16'd3) begin errors++; $display("[TB] FAIL filter_dropped: got %0d want 3", dropped_count); end
   endtask

   task automatic test_backpressure();
      logic [7:0] bs[$];
      int sent, busyAt, n;
      logic busy1, busy2;
      bit doSend;
      gotQ.delete(); expQ.delete();
      step(1'b0, 8'h00, 3'd0, 1'b0, 1'b1);
      for (int i = 0; i < 64; i++) bs.push_back(8'($urandom_range(0, 255)));
      sent = 0; busyAt = -1; busy1 = 1'b0; busy2 = 1'b0;
      for (int c = 0; c < 70; c++) begin
         doSend = (sent < 64) && !busy2;
         step(doSend, doSend ? bs[sent] : 8'h00, 3'd0, 1'b0, 1'b0);
         if (sampledBusy === 1'b1 && busyAt < 0) busyAt = sent;
         if (doSend) sent++;
         busy2 = busy1;
         busy1 = sampledBusy;
      end
      checks++; if (busyAt != 48) begin errors++; $display("[TB] FAIL bp_busy_rise: got %0d bytes want 48", busyAt); end
      checks++; if (sent != 50) begin errors++; $display("[TB] FAIL bp_bytes_before_stop: got %0d want 50", sent); end
      checks++; if (gotQ.size() != 0) begin errors++; $display("[TB] FAIL bp_no_pop: got %0d want 0", gotQ.size()); end
      n = 0;
      while (gotQ.size() < 4 && n < 300) begin
         doSend = (sent < 64) && !busy2;
         step(doSend, doSend ? bs[sent] : 8'h00, 3'd0, 1'b1, 1'b0);
         if (doSend) sent++;
         busy2 = busy1;
         busy1 = sampledBusy;
         n++;
      end
      checks++; if (n >= 300) begin errors++; $display("[TB] FAIL bp_timeout: got %0d words want 4", gotQ.size()); end
      for (int w = 0; w < 4; w++) begin
         if (w < gotQ.size()) begin
            checks++; if (gotQ[w] !== packFrom(bs, 16*w)) begin errors++; $display("[TB] FAIL bp_word%0d: got %h want %h", w, gotQ[w], packFrom(bs, 16*w)); end
         end
      end
      checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL bp_overflow: got %b want 0", overflow); end
      checks++; if (dropped_count !== '0) begin errors++; $display("[TB] FAIL bp_dropped: got %0d want 0", dropped_count); end
   endtask

   task automatic test_overflow();
      logic [7:0] bs[$];
      int n;
      gotQ.delete(); expQ.delete();
      step(1'b0, 8'h00, 3'd0, 1'b0, 1'b1);
      for (int i = 0; i < 96; i++) bs.push_back(8'($urandom_range(0, 255)));
      for (int i = 0; i < 96; i++) step(1'b1, bs[i], 3'd0, 1'b0, 1'b0);
      step(1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
      checks++; if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL ovf_flag: got %b want 1", overflow); end
      checks++; if (dropped_count !== 16'd16) begin errors++; $display("[TB] FAIL ovf_dropped: got %0d want 16", dropped_count); end
      checks++; if (rx_busy !== 1'b1) begin errors++; $display("[TB] FAIL ovf_busy: got %b want 1", rx_busy); end
      step(1'b0, 8'h00, 3'd0, 1'b0, 1'b1);
      step(1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
      checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL ovf_clear_flag: got %b want 0", overflow); end
      checks++; if (dropped_count !== '0) begin errors++; $display("[TB] FAIL ovf_clear_count: got %0d want 0", dropped_count); end
      drain(n);
      checks++; if (gotQ.size() != 5) begin errors++; $display("[TB] FAIL ovf_words: got %0d want 5", gotQ.size()); end
      for (int w = 0; w < 5; w++) begin
         if (w < gotQ.size()) begin
            checks++; if (gotQ[w] !== packFrom(bs, 16*w)) begin errors++; $display("[TB] FAIL ovf_word%0d: got %h want %h", w, gotQ[w], packFrom(bs, 16*w)); end
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] bs[$];
      int n;
      gotQ.delete(); expQ.delete();
      step(1'b0, 8'h00, 3'd0, 1'b0, 1'b1);
      for (int i = 0; i < 81; i++) bs.push_back(8'($urandom_range(0, 255)));
      for (int i = 0; i < 79; i++) step(1'b1, bs[i], 3'd0, 1'b0, 1'b0);
      step(1'b1, bs[79], 3'd0, 1'b1, 1'b0);
      step(1'b1, bs[80], 3'd0, 1'b0, 1'b0);
      step(1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
      checks++; if (dropped_count !== '0) begin errors++; $display("[TB] FAIL b2b_dropped: got %0d want 0", dropped_count); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL b2b_overflow: got %b want 0", overflow); end
      checks++; if (gotQ.size() != 1) begin errors++; $display("[TB] FAIL b2b_first_pop: got %0d want 1", gotQ.size()); end
      drain(n);
      checks++; if (gotQ.size() != 5) begin errors++; $display("[TB] FAIL b2b_words: got %0d want 5", gotQ.size()); end
      for (int w = 0; w < 5; w++) begin
         if (w < gotQ.size()) begin
            checks++; if (gotQ[w] !== packFrom(bs, 16*w)) begin errors++; $display("[TB] FAIL b2b_word%0d: got %h want %h", w, gotQ[w], packFrom(bs, 16*w)); end
         end
      end
   endtask

   task automatic test_reset_mid_word();
      logic [7:0] fresh[$];
      int n;
      doReset();
      releaseReset();
      gotQ.delete(); expQ.delete();
      for (int i = 0; i < 23; i++) step(1'b1, 8'($urandom_range(0, 255)), 3'd0, 1'b0, 1'b0);
      step(1'b1, 8'hEE, 3'd6, 1'b0, 1'b0);
      step(1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
      checks++; if (valid !== 1'b1) begin errors++; $display("[TB] FAIL rst_pre_valid: got %b want 1", valid); end
      doReset();
      checks++; if (valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_valid: got %b want 0", valid); end
      checks++; if (data !== 128'h0) begin errors++; $display("[TB] FAIL rst_mid_data: got %h want 0", data); end
      checks++; if (rx_busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_busy: got %b want 0", rx_busy); end
      checks++; if (dropped_count !== '0) begin errors++; $display("[TB] FAIL rst_mid_dropped: got %0d want 0", dropped_count); end
      releaseReset();
      for (int i = 0; i < 16; i++) fresh.push_back(8'($urandom_range(0, 255)));
      for (int i = 0; i < 16; i++) step(1'b1, fresh[i], 3'd0, 1'b1, 1'b0);
      drain(n);
      checks++; if (gotQ.size() != 1) begin errors++; $display("[TB] FAIL rst_fresh_count: got %0d want 1", gotQ.size()); end
      else begin
         checks++; if (gotQ[0] !== packFrom(fresh, 0)) begin errors++; $display("[TB] FAIL rst_fresh_word: got %h want %h", gotQ[0], packFrom(fresh, 0)); end
      end
   endtask

   task automatic test_random();
      int n;
      bit bv, rdy, clr;
      logic [2:0] ch;
      gotQ.delete(); expQ.delete();
      rdy = 1'b1;
      for (int c = 0; c < 600; c++) begin
         if ((c % 8) == 0) rdy = ($urandom_range(0, 2) != 0);
         bv  = ($urandom_range(0, 3) != 0);
         ch  = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
         clr = ($urandom_range(0, 99) == 0);
         step(bv, 8'($urandom_range(0, 255)), ch, rdy, clr);
      end
      step(1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
      checks++; if (dropped_count !== CNT_W'(mDropped)) begin errors++; $display("[TB] FAIL rand_dropped: got %0d want %0d", dropped_count, mDropped); end
      checks++; if (overflow !== mOverflow) begin errors++; $display("[TB] FAIL rand_overflow: got %b want %b", overflow, mOverflow); end
      drain(n);
      checks++; if (gotQ.size() != expQ.size()) begin errors++; $display("[TB] FAIL rand_count: got %0d want %0d", gotQ.size(), expQ.size()); end
      else begin
         n = -1;
         for (int i = 0; i < gotQ.size(); i++) if (n < 0 && gotQ[i] !== expQ[i]) n = i;
         checks++; if (n >= 0) begin errors++; $display("[TB] FAIL rand_word%0d: got %h want %h", n, gotQ[n], expQ[n]); end
      end
      checks++; if (valid !== 1'b0) begin errors++; $display("[TB] FAIL rand_drained: got %b want 0", valid); end
   endtask

   // Scenario sequence followed by the single summary line.
   initial begin
      modelReset();
      test_reset();
      test_single_word();
      test_channel_filter();
      test_backpressure();
      test_overflow();
      test_back_to_back();
      test_reset_mid_word();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
